// File: rtl/wallace_mac_seq.sv
// Sequential multiply-accumulate around a 4x4 Wallace-tree multiplier.
// Operand pairs arrive over valid/ready and are registered into the multiplier.
// Each product is added to a wide accumulator one clock after its accept.
// After BEAT_COUNT products the sum is held on a valid/ready result port.

// 4x4 unsigned Wallace-tree multiplier: one 3:2 layer on the partial-product
// columns, a second 3:2 layer on the resulting rows, then a carry-propagate add.
module wallace_multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  logic [3:0] pp [4];
  logic       s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
  logic [6:0] row_a, row_b, row_c, maj;
  logic [7:0] sum_row, carry_row;

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Partial products: pp[i][j] = A[j] & B[i], weight i+j
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = A & {4{B[i]}};
    end
  end

  assign {c1, s1} = ha(pp[0][1], pp[1][0]);
  assign {c2, s2} = fa(pp[0][2], pp[1][1], pp[2][0]);
  assign {c3, s3} = fa(pp[0][3], pp[1][2], pp[2][1]);
  assign {c4, s4} = fa(pp[1][3], pp[2][2], pp[3][1]);
  assign {c5, s5} = ha(pp[2][3], pp[3][2]);

  // Three rows left after the column layer; pp[3][0] passes straight through.
  assign row_a = {pp[3][3], s5, s4, s3, s2, s1, pp[0][0]};
  assign row_b = {c5, c4, c3, c2, c1, 2'b00};
  assign row_c = {3'b000, pp[3][0], 3'b000};

  assign maj       = (row_a & row_b) | (row_a & row_c) | (row_b & row_c);
  assign sum_row   = {1'b0, row_a ^ row_b ^ row_c};
  assign carry_row = {maj, 1'b0};
  assign P         = sum_row + carry_row;

endmodule

module wallace_mac_seq #(
  parameter int BEAT_COUNT = 4,
  parameter int ACC_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(BEAT_COUNT + 1);
  localparam logic [CNT_W-1:0] BEATS = CNT_W'(BEAT_COUNT);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] beat_cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       a_q, b_q;
  logic             p_vld;
  logic [7:0]       p;
  logic [ACC_W:0]   acc_sum;
  logic             accept, out_hs, last_beat;

  // Zero-extend both terms so the top bit of the result is the carry out.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc_v,
                                             input logic [7:0]       p_v);
    return {1'b0, acc_v} + (ACC_W+1)'(p_v);
  endfunction

  wallace_multiplier u_mult (
    .A (a_q),
    .B (b_q),
    .P (p)
  );

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_beat = (beat_cnt == BEATS - CNT_W'(1));
  assign acc_sum   = acc_add(acc, p);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; BEAT_COUNT==1 falls out of last_beat being true in IDLE
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = last_beat ? DRAIN : ACCUM;
      ACCUM: if (accept && last_beat) next_state = DRAIN;
      DRAIN: next_state = HOLD;
      HOLD:  if (out_hs) next_state = IDLE;
    endcase
  end

  // Output decode; the result port mirrors the accumulator in every state
  always_comb begin
    in_ready = ((state == IDLE) || (state == ACCUM)) && (beat_cnt < BEATS);
    busy     = (state != IDLE);
    acc_out  = acc;
    acc_ovf  = ovf;
  end

  // Registered out_valid, high exactly while in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= (next_state == HOLD);
  end

  // ---- stage p0: capture operands into the multiplier on accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p_vld    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      if (out_hs)      beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // ---- stage p1: add the product one clock after its accept ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (out_hs) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (p_vld) begin
      acc <= acc_sum[ACC_W-1:0];
      ovf <= ovf | acc_sum[ACC_W];
    end
  end

endmodule
